// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and downstream hold.
// Optional BUBBLE_CNT_EN adds a free-running count of inserted bubbles.
module id_ex_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_d,
    input  logic            mem_write_d,
    input  logic            alu_src_d,
    input  logic            reg_write_d,
    input  logic            jump_d,
    input  logic            branch_d,
    input  logic            jalr_d,
    input  logic [1:0]      result_src_d,
    input  logic [2:0]      alu_control_d,
    input  logic [2:0]      func3_d,
    input  logic [XLEN-1:0] rd1_d,
    input  logic [XLEN-1:0] rd2_d,
    input  logic [XLEN-1:0] imm_ext_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pc_plus4_d,
    input  logic [RA_W-1:0] rs1_d,
    input  logic [RA_W-1:0] rs2_d,
    input  logic [RA_W-1:0] rd_d,
    input  logic            flush_e,
    input  logic            stall_e,
    output logic            valid_e,
    output logic            mem_write_e,
    output logic            alu_src_e,
    output logic            reg_write_e,
    output logic            jump_e,
    output logic            branch_e,
    output logic            jalr_e,
    output logic [1:0]      result_src_e,
    output logic [2:0]      alu_control_e,
    output logic [2:0]      func3_e,
    output logic [XLEN-1:0] rd1_e,
    output logic [XLEN-1:0] rd2_e,
    output logic [XLEN-1:0] imm_ext_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] pc_plus4_e,
    output logic [RA_W-1:0] rs1_e,
    output logic [RA_W-1:0] rs2_e,
    output logic [RA_W-1:0] rd_e,
    output logic            stall_d
`ifdef BUBBLE_CNT_EN
    ,
    output logic [31:0]     bubble_count
`endif
);

    localparam logic [2:0] AluAdd = 3'b010;

    typedef enum logic [1:0] {ModeLoad, ModeHold, ModeBubble} mode_t;

    logic  lu;
    mode_t mode;

    // rs2 is compared even for I-type instructions; the occasional spurious stall is accepted.
    assign lu = valid_e & reg_write_e & (result_src_e == 2'b01) & (rd_e != '0) & valid_d &
                ((rs1_d == rd_e) | (rs2_d == rd_e));

    assign stall_d = lu | stall_e;

    // Flush outranks stall so a resolved branch always owns the EX slot.
    always_comb begin
        mode = ModeLoad;
        if (flush_e) begin
            mode = ModeBubble;
        end else if (stall_e) begin
            mode = ModeHold;
        end else if (lu) begin
            mode = ModeBubble;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_e       <= 1'b0;
            mem_write_e   <= 1'b0;
            alu_src_e     <= 1'b0;
            reg_write_e   <= 1'b0;
            jump_e        <= 1'b0;
            branch_e      <= 1'b0;
            jalr_e        <= 1'b0;
            result_src_e  <= 2'b00;
            alu_control_e <= AluAdd;
            func3_e       <= 3'b000;
            rd1_e         <= '0;
            rd2_e         <= '0;
            imm_ext_e     <= '0;
            pc_e          <= '0;
            pc_plus4_e    <= '0;
            rs1_e         <= '0;
            rs2_e         <= '0;
            rd_e          <= '0;
        end else begin
            case (mode)
                ModeBubble: begin
                    valid_e       <= 1'b0;
                    mem_write_e   <= 1'b0;
                    alu_src_e     <= 1'b0;
                    reg_write_e   <= 1'b0;
                    jump_e        <= 1'b0;
                    branch_e      <= 1'b0;
                    jalr_e        <= 1'b0;
                    result_src_e  <= 2'b00;
                    alu_control_e <= AluAdd;
                    func3_e       <= 3'b000;
                    rd1_e         <= '0;
                    rd2_e         <= '0;
                    imm_ext_e     <= '0;
                    pc_e          <= '0;
                    pc_plus4_e    <= '0;
                    rs1_e         <= '0;
                    rs2_e         <= '0;
                    rd_e          <= '0;
                end
                ModeLoad: begin
                    // An empty decode slot must not carry any side-effecting control into EX.
                    valid_e       <= valid_d;
                    mem_write_e   <= mem_write_d & valid_d;
                    alu_src_e     <= alu_src_d;
                    reg_write_e   <= reg_write_d & valid_d;
                    jump_e        <= jump_d & valid_d;
                    branch_e      <= branch_d & valid_d;
                    jalr_e        <= jalr_d & valid_d;
                    result_src_e  <= result_src_d;
                    alu_control_e <= alu_control_d;
                    func3_e       <= func3_d;
                    rd1_e         <= rd1_d;
                    rd2_e         <= rd2_d;
                    imm_ext_e     <= imm_ext_d;
                    pc_e          <= pc_d;
                    pc_plus4_e    <= pc_plus4_d;
                    rs1_e         <= rs1_d;
                    rs2_e         <= rs2_d;
                    rd_e          <= rd_d;
                end
                default: ;
            endcase
        end
    end

`ifdef BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_q;

    assign bubble_count = bubble_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= 32'd0;
        end else if (mode == ModeBubble) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end
`endif

endmodule
